// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART state encoding and frame-configuration types.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Widest divider a frame-config record can hold; DIV_WIDTH must not exceed it.
    localparam int UART_DIV_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    typedef struct packed {
        logic [UART_DIV_W-1:0] div;
        logic                  parity_en;
        logic                  parity_odd;
        logic                  two_stop;
    } uart_cfg_t;

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// Module  : uart_bit_timer
// Brief   : Reloadable bit-period counter; pulses bit_end_o every max(div,1) cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bit_timer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 reload_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 bit_end_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] last_cnt;

    // Divider values 0 and 1 both give a one-cycle bit period.
    assign last_cnt  = (div_i > DIV_WIDTH'(1)) ? (div_i - DIV_WIDTH'(1)) : '0;
    assign bit_end_o = en_i && (cnt_q == last_cnt);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else if (reload_i || bit_end_o) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + DIV_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module  : uart_tx
// Brief   : Valid/ready fed UART transmitter, LSB first, optional parity, 1/2 stops.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic [DIV_WIDTH-1:0]  clk_div_i,
    input  logic                  parity_en_i,
    input  logic                  parity_odd_i,
    input  logic                  two_stop_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  data_in_valid_i,
    output logic                  data_in_ready_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int                IDX_W    = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_state_e           state_q;
    uart_cfg_t             cfg_q;
    uart_cfg_t             cfg_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  stop_idx_q;
    logic                  par_q;
    logic                  tx_q;

    logic                  bit_end;
    logic                  last_stop;
    logic                  accept;

    always_comb begin
        cfg_d            = '0;
        cfg_d.div        = UART_DIV_W'(clk_div_i);
        cfg_d.parity_en  = parity_en_i;
        cfg_d.parity_odd = parity_odd_i;
        cfg_d.two_stop   = two_stop_i;
    end

    // Ready opens in the final stop bit-end cycle so frames can abut with no gap.
    assign last_stop       = (state_q == STOP) && bit_end && (!cfg_q.two_stop || stop_idx_q);
    assign data_in_ready_o = (state_q == IDLE) || last_stop;
    assign accept          = data_in_valid_i && data_in_ready_o;
    assign busy_o          = (state_q != IDLE);
    assign tx_o            = tx_q;

    uart_bit_timer #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_bit_timer (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .reload_i  (accept),
        .en_i      (state_q != IDLE),
        .div_i     (cfg_q.div[DIV_WIDTH-1:0]),
        .bit_end_o (bit_end)
    );

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else if (accept) begin
            state_q    <= START;
            cfg_q      <= cfg_d;
            shift_q    <= data_in_i;
            idx_q      <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b0;
        end else if (bit_end) begin
            case (state_q)
                START: begin
                    state_q <= DATA;
                    idx_q   <= '0;
                    par_q   <= cfg_q.parity_odd;
                    tx_q    <= shift_q[0];
                end
                DATA: begin
                    // Running parity folds in each bit as it leaves the shifter.
                    par_q <= par_q ^ shift_q[0];
                    if (idx_q != LAST_IDX) begin
                        shift_q <= shift_q >> 1;
                        idx_q   <= idx_q + IDX_W'(1);
                        tx_q    <= shift_q[1];
                    end else if (cfg_q.parity_en) begin
                        state_q <= PARITY;
                        tx_q    <= par_q ^ shift_q[0];
                    end else begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                end
                STOP: begin
                    if (last_stop) begin
                        state_q <= IDLE;
                    end else begin
                        stop_idx_q <= 1'b1;
                    end
                    tx_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module  : tb_uart_tx
// Brief   : Scoreboard bench for uart_tx with a frame-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            p;
        bit            pe;
        bit            po;
        bit            ts;
        int            start;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          arst_ni = 1'b0;
    logic [15:0]   clk_div_i = '0;
    logic          parity_en_i = 1'b0;
    logic          parity_odd_i = 1'b0;
    logic          two_stop_i = 1'b0;
    logic [DW-1:0] data_in_i = '0;
    logic          data_in_valid_i = 1'b0;
    logic          data_in_ready_o;
    logic          tx_o;
    logic          busy_o;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_active = 1'b0;
    exp_t sb[$];

    uart_tx #(
        .DATA_WIDTH (DW),
        .DIV_WIDTH  (16)
    ) dut (
        .clk_i           (clk_i),
        .arst_ni         (arst_ni),
        .clk_div_i       (clk_div_i),
        .parity_en_i     (parity_en_i),
        .parity_odd_i    (parity_odd_i),
        .two_stop_i      (two_stop_i),
        .data_in_i       (data_in_i),
        .data_in_valid_i (data_in_valid_i),
        .data_in_ready_o (data_in_ready_o),
        .tx_o            (tx_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference frame: bit slot b of length p; slot 0 start, then data LSB first,
    // optional parity, then stop slots high.
    function automatic logic exp_bit(input exp_t e, input int k);
        int b;
        b = k / e.p;
        if (b == 0) return 1'b0;
        if (b <= DW) return e.data[b-1];
        if (e.pe && b == DW + 1) return (^e.data) ^ e.po;
        return 1'b1;
    endfunction

    function automatic int frame_len(input exp_t e);
        return e.p * (1 + DW + int'(e.pe) + 1 + int'(e.ts));
    endfunction

    // Monitor: every low bit on an idle line opens a frame that is checked cycle by cycle.
    initial begin
        exp_t e;
        int   len, tx_err, rdy_err, busy_err;
        bit   aborted;
        forever begin
            @(negedge clk_i);
            if (!arst_ni || tx_o !== 1'b0) continue;
            if (sb.size() == 0) begin
                check("unexpected_start", 1, 0);
                continue;
            end
            e = sb.pop_front();
            mon_active = 1'b1;
            check($sformatf("start_cycle_%02h", e.data), cyc, e.start);
            len = frame_len(e);
            tx_err = 0; rdy_err = 0; busy_err = 0; aborted = 1'b0;
            for (int k = 0; k < len; k++) begin
                if (k > 0) @(negedge clk_i);
                if (!arst_ni) begin
                    aborted = 1'b1;
                    break;
                end
                if (tx_o !== exp_bit(e, k)) tx_err++;
                if (data_in_ready_o !== (k == len - 1)) rdy_err++;
                if (busy_o !== 1'b1) busy_err++;
            end
            if (!aborted) begin
                check($sformatf("frame_tx_%02h_badcycles", e.data), tx_err, 0);
                check($sformatf("frame_ready_%02h_badcycles", e.data), rdy_err, 0);
                check($sformatf("frame_busy_%02h_badcycles", e.data), busy_err, 0);
            end
            mon_active = 1'b0;
        end
    end

    // Present one word at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [DW-1:0] d, input int div, input bit pe, input bit po,
                        input bit ts, input bit keep_valid);
        exp_t e;
        bit   ok;
        data_in_i = d; clk_div_i = 16'(div);
        parity_en_i = pe; parity_odd_i = po; two_stop_i = ts;
        data_in_valid_i = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (data_in_ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (!ok) begin
            check("ready_timeout", 0, 1);
            data_in_valid_i = 1'b0;
            return;
        end
        e.data = d; e.p = (div <= 1) ? 1 : div;
        e.pe = pe; e.po = po; e.ts = ts; e.start = cyc + 1;
        sb.push_back(e);
        @(negedge clk_i);
        if (!keep_valid) begin
            data_in_valid_i = 1'b0;
            data_in_i    = DW'($urandom);
            clk_div_i    = 16'($urandom_range(0, 9));
            parity_en_i  = 1'($urandom);
            parity_odd_i = 1'($urandom);
            two_stop_i   = 1'($urandom);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (sb.size() != 0 || mon_active); i++) @(negedge clk_i);
        check("drain_pending", sb.size() + int'(mon_active), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_tx", tx_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_ready", data_in_ready_o, 1);
        arst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        check("idle_tx", tx_o, 1);

        send(8'hA5, 4, 0, 0, 0, 0);
        drain();
        send(8'h07, 4, 1, 0, 0, 0);
        drain();
        send(8'h07, 4, 1, 1, 0, 0);
        drain();
        send(8'h3B, 4, 0, 0, 1, 0);
        drain();

        send(8'h01, 4, 0, 0, 0, 1);
        send(8'h80, 4, 0, 0, 0, 0);
        drain();

        // Config changes while a frame is on the line.
        send(8'h5A, 4, 0, 0, 0, 0);
        repeat (10) @(negedge clk_i);
        clk_div_i = 16'd8; parity_en_i = 1'b1;
        drain();
        send(8'hC3, 8, 1, 0, 0, 0);
        drain();

        // Reset in the middle of the data bits.
        send(8'h96, 4, 0, 0, 0, 0);
        repeat (12) @(negedge clk_i);
        #3 arst_ni = 1'b0;
        @(negedge clk_i);
        check("midrst_tx", tx_o, 1);
        check("midrst_busy", busy_o, 0);
        check("midrst_ready", data_in_ready_o, 1);
        repeat (2) @(negedge clk_i);
        sb.delete();
        arst_ni = 1'b1;
        @(negedge clk_i);
        send(8'h69, 4, 0, 0, 0, 0);
        drain();

        send(8'h3C, 0, 0, 0, 0, 0);
        drain();
        send(8'h3C, 1, 0, 0, 0, 0);
        drain();

        for (int i = 0; i < 40; i++) begin
            bit kv;
            kv = (i != 39) && ($urandom_range(0, 2) == 0);
            send(DW'($urandom), $urandom_range(0, 6), 1'($urandom), 1'($urandom),
                 1'($urandom), kv);
            if (!kv) repeat ($urandom_range(0, 4)) @(negedge clk_i);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
